// File: rtl/sdm_pkg.sv
// Shared constants and the output saturation helper for the stereo
// sigma-delta demodulator.
package sdm_pkg;

  localparam int SDM_DW     = 15;
  localparam int CIC_N      = 3;
  localparam int CIC_RLOG   = 4;
  localparam int CIC_R      = 1 << CIC_RLOG;
  localparam int CIC_W      = 2 + CIC_N * CIC_RLOG;
  localparam int CIC_OSHIFT = 2;
  localparam int CIC_SHW    = CIC_W + CIC_OSHIFT;

  localparam logic [SDM_DW-1:0] SAT_MAX = 15'h3FFF;
  localparam logic [SDM_DW-1:0] SAT_MIN = 15'h4000;

  // Number of outputs suppressed after reset while the comb delays fill.
  localparam logic [1:0] WARM_N = 2'd3;

  // Clamp the shifted CIC result into the signed PCM range. The value fits
  // when every bit above the PCM sign bit equals that sign bit.
  function automatic logic [SDM_DW-1:0] sat_pcm(input logic [CIC_SHW-1:0] v);
    logic [CIC_SHW-SDM_DW:0] top;
    top = v[CIC_SHW-1:SDM_DW-1];
    if ((top == '0) || (top == '1)) begin
      sat_pcm = v[SDM_DW-1:0];
    end else if (v[CIC_SHW-1]) begin
      sat_pcm = SAT_MIN;
    end else begin
      sat_pcm = SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/sdm_decim_cic_chan.sv
// One CIC decimator channel: integrators at the bit rate, a capture
// register, the comb chain at the decimated rate, and output saturation.
module cic_chan
  import sdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              din,
  input  logic              cap_en,
  input  logic              comb_en,
  output logic [SDM_DW-1:0] dout
);

  logic signed [CIC_W-1:0] r_i1, r_i2, r_i3;
  logic signed [CIC_W-1:0] r_cap;
  logic signed [CIC_W-1:0] r_d1, r_d2, r_d3;
  logic [SDM_DW-1:0]       r_dout;

  logic signed [CIC_W-1:0] w_x;
  logic signed [CIC_W-1:0] w_c1, w_c2, w_c3;
  logic [CIC_SHW-1:0]      w_y;

  // A 1 bit is +1, a 0 bit is -1 (all ones in two's complement).
  assign w_x  = din ? {{(CIC_W-1){1'b0}}, 1'b1} : {CIC_W{1'b1}};

  // Comb chain; all differences wrap modulo 2^W, which cancels integrator wrap.
  assign w_c1 = r_cap - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;
  assign w_y  = {w_c3, {CIC_OSHIFT{1'b0}}};

  // Integrators advance only on valid bitstream samples, each from old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
    end else if (bit_en) begin
      r_i1 <= r_i1 + w_x;
      r_i2 <= r_i2 + r_i1;
      r_i3 <= r_i3 + r_i2;
    end else begin
      r_i1 <= r_i1;
      r_i2 <= r_i2;
      r_i3 <= r_i3;
    end
  end

  // Capture the last integrator once it includes the R-th sample of the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap <= '0;
    end else if (cap_en) begin
      r_cap <= r_i3;
    end else begin
      r_cap <= r_cap;
    end
  end

  // Comb delay update and saturated output register, once per decimated sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d1   <= '0;
      r_d2   <= '0;
      r_d3   <= '0;
      r_dout <= '0;
    end else if (comb_en) begin
      r_d1   <= r_cap;
      r_d2   <= w_c1;
      r_d3   <= w_c2;
      r_dout <= sat_pcm(w_y);
    end else begin
      r_d1   <= r_d1;
      r_d2   <= r_d2;
      r_d3   <= r_d3;
      r_dout <= r_dout;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/sdm_decim.sv
// Stereo sigma-delta demodulator: shared decimation counter and tick
// pipeline driving two CIC channels, plus warm-up gating of valid.
module sdm_decim
  import sdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              left_in,
  input  logic              right_in,
  output logic [SDM_DW-1:0] ldata,
  output logic [SDM_DW-1:0] rdata,
  output logic              valid
);

  logic [CIC_RLOG-1:0] r_cnt;
  logic                r_cap_en;
  logic                r_comb_en;
  logic [1:0]          r_warm;
  logic                r_valid;
  logic                w_dec_tick;

  // The R-th valid bit of each period closes a decimation window.
  assign w_dec_tick = bit_en & (r_cnt == {CIC_RLOG{1'b1}});

  // Decimation counter and the two-stage tick pipeline (capture, then comb).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_cap_en  <= 1'b0;
      r_comb_en <= 1'b0;
    end else begin
      if (bit_en) begin
        r_cnt <= r_cnt + {{(CIC_RLOG-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      r_cap_en  <= w_dec_tick;
      r_comb_en <= r_cap_en;
    end
  end

  // Output strobe, suppressed for the first WARM_N outputs after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm  <= 2'd0;
      r_valid <= 1'b0;
    end else if (r_comb_en) begin
      if (r_warm == WARM_N) begin
        r_warm  <= r_warm;
        r_valid <= 1'b1;
      end else begin
        r_warm  <= r_warm + 2'd1;
        r_valid <= 1'b0;
      end
    end else begin
      r_warm  <= r_warm;
      r_valid <= 1'b0;
    end
  end

  cic_chan u_left (
    .clk     (clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .din     (left_in),
    .cap_en  (r_cap_en),
    .comb_en (r_comb_en),
    .dout    (ldata)
  );

  cic_chan u_right (
    .clk     (clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .din     (right_in),
    .cap_en  (r_cap_en),
    .comb_en (r_comb_en),
    .dout    (rdata)
  );

  assign valid = r_valid;

endmodule

// File: tb/tb_sdm_decim.sv
// Directed self-checking bench for sdm_decim.
module tb_sdm_decim;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_en = 1'b0;
  logic left_in = 1'b0;
  logic right_in = 1'b0;
  logic signed [14:0] ldata;
  logic signed [14:0] rdata;
  logic valid;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side timing model: bit counter, tick delay line, warm-up count.
  int m_cnt = 0;
  int m_warm = 0;
  bit m_p0 = 1'b0;
  bit m_p1 = 1'b0;
  bit m_seen = 1'b0;
  int exp_l = 0;
  int exp_r = 0;
  int g_tol = 0;
  int n_valid = 0;

  sdm_decim dut (
    .clk      (clk),
    .reset    (reset),
    .bit_en   (bit_en),
    .left_in  (left_in),
    .right_in (right_in),
    .ldata    (ldata),
    .rdata    (rdata),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v, input int tol);
    n_checks++;
    if ((obs - exp_v > tol) || (exp_v - obs > tol)) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp_v, tol, $time);
    end
  endtask

  // Apply one clock of inputs, then check the outputs just after the edge.
  task automatic step(input logic be, input logic l, input logic r, input logic rst);
    bit tick;
    bit fire;
    bit exp_valid;
    reset = rst;
    bit_en = be;
    left_in = l;
    right_in = r;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0;
      m_warm = 0;
      m_p0 = 1'b0;
      m_p1 = 1'b0;
      m_seen = 1'b0;
      exp_valid = 1'b0;
    end else begin
      tick = be && (m_cnt == 15);
      if (be) m_cnt = (m_cnt + 1) % 16;
      fire = m_p1;
      m_p1 = m_p0;
      m_p0 = tick;
      exp_valid = fire && (m_warm == 3);
      if (fire && (m_warm < 3)) m_warm++;
    end
    check("valid", int'(valid), int'(exp_valid), 0);
    if (valid) n_valid++;
    if (exp_valid) begin
      m_seen = 1'b1;
      check("ldata", int'(ldata), exp_l, g_tol);
      check("rdata", int'(rdata), exp_r, g_tol);
    end else if (m_seen) begin
      check("ldata_hold", int'(ldata), exp_l, g_tol);
      check("rdata_hold", int'(rdata), exp_r, g_tol);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_valid = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc;
    int v;
    bit b;

    // Reset state
    do_reset();
    check("rst_ldata", int'(ldata), 0, 0);
    check("rst_rdata", int'(rdata), 0, 0);
    check("rst_valid", int'(valid), 0, 0);

    // Case 1: DC full scale, left +1 saturates, right -1 lands exactly on min
    exp_l = 16383; exp_r = -16384; g_tol = 0;
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    flush();
    check("c1_nvalid", n_valid, 5, 0);

    // Case 2: alternating bits average to zero over every window
    do_reset();
    exp_l = 0; exp_r = 0;
    for (int i = 0; i < 128; i++) step(1'b1, (i % 2) == 0, (i % 2) == 0, 1'b0);
    flush();
    check("c2_nvalid", n_valid, 5, 0);

    // Case 3: sparse strobes, state holds between them
    do_reset();
    exp_l = 16383; exp_r = 16383;
    for (int i = 0; i < 288; i++) step((i % 3) == 0, 1'b1, 1'b1, 1'b0);
    flush();
    check("c3_nvalid", n_valid, 3, 0);

    // Case 4: loopback of a first-order modulator fed 15'h1000 (0.25 of full scale)
    do_reset();
    exp_l = (4096 * 4096 * 4) / 16384;
    exp_r = exp_l;
    g_tol = 64;
    acc = 0;
    for (int i = 0; i < 160; i++) begin
      v = acc + 4096;
      b = (v >= 0);
      acc = v - (b ? 16384 : -16384);
      step(1'b1, b, b, 1'b0);
    end
    flush();
    check("c4_nvalid", n_valid, 7, 0);
    g_tol = 0;

    // Case 5: reset mid-period at cnt = 7 discards everything
    do_reset();
    exp_l = 16383; exp_r = 16383;
    for (int i = 0; i < 23; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("c5_pre_ldata", int'(ldata != 15'sd0), 1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("c5_rst_ldata", int'(ldata), 0, 0);
    check("c5_rst_rdata", int'(rdata), 0, 0);
    check("c5_rst_valid", int'(valid), 0, 0);
    n_valid = 0;
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    flush();
    check("c5_nvalid", n_valid, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
